// File: rtl/alu_issue_stage.sv
// alu_issue_stage: FIFO-buffered operand issue and registered result capture around a 4-bit ALU.
// Optional delivered-result counter (ops_done) is built when ALU_ISSUE_CNT_EN is defined.
module alu_issue_stage #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic [2:0] in_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_result,
  input  logic       alu_zero,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_result,
  output logic       out_zero
`ifdef ALU_ISSUE_CNT_EN
  ,
  output logic [7:0] ops_done
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  // Entry layout: {a[3:0], b[3:0], sel[2:0]}
  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_d;
  logic          r_out_valid;
  logic [3:0]    r_out_result;
  logic          r_out_zero;
  logic [1:0]    r_state;
  logic [1:0]    w_state_d;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_issue;
  logic          w_out_valid_d;
  logic          w_idle_d;
  logic [10:0]   w_head;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_issue  = !w_empty && (!r_out_valid || out_ready);

  assign w_head  = r_mem[r_rd_ptr];
  assign alu_a   = w_empty ? 4'd0 : w_head[10:7];
  assign alu_b   = w_empty ? 4'd0 : w_head[6:3];
  assign alu_sel = w_empty ? 3'd0 : w_head[2:0];

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_zero   = r_out_zero;

  // Storage array carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_a, in_b, in_sel};
    end
  end

  always_comb begin
    w_count_d = r_count;
    case ({w_push, w_issue})
      2'b10:   w_count_d = r_count + (AW+1)'(1);
      2'b01:   w_count_d = r_count - (AW+1)'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= 4'd0;
      r_out_zero   <= 1'b0;
    end else if (w_issue) begin
      r_out_valid  <= 1'b1;
      r_out_result <= alu_result;
      r_out_zero   <= alu_zero;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign w_out_valid_d = w_issue || (r_out_valid && !out_ready);
  assign w_idle_d      = (w_count_d == '0) && !w_out_valid_d;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_idle_d) w_state_d = S_RUN;
      end
      S_RUN: begin
        if (w_idle_d) begin
          w_state_d = S_IDLE;
        end else if (w_out_valid_d && (w_count_d != '0) && !out_ready) begin
          w_state_d = S_STALL;
        end
      end
      S_STALL: begin
        if (w_idle_d) begin
          w_state_d = S_IDLE;
        end else if (out_ready) begin
          w_state_d = S_RUN;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

`ifdef ALU_ISSUE_CNT_EN
  logic [7:0] r_ops_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ops_done <= 8'd0;
    end else if (r_out_valid && out_ready) begin
      r_ops_done <= r_ops_done + 8'd1;
    end
  end

  assign ops_done = r_ops_done;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural stand-in for the 4-bit ALU.
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_sel;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_zero;
`ifdef ALU_ISSUE_CNT_EN
  logic [7:0] ops_done;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int valid_cycles = 0;
  logic [4:0] exp_q[$];
  bit         held = 1'b0;
  logic [4:0] held_val;

  alu_issue_stage #(.DEPTH(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero)
`ifdef ALU_ISSUE_CNT_EN
    ,
    .ops_done   (ops_done)
`endif
  );

  always #5 clk = ~clk;

  // ALU stand-in: 000 add, 001 sub, 100 xor, 110 not A
  always_comb begin
    case (alu_sel)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b110:  alu_result = ~alu_a;
      default: alu_result = alu_a & alu_b;
    endcase
    alu_zero = (alu_result == 4'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Delivery monitor: in-order scoreboard plus hold-stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (out_valid) valid_cycles++;
      if (held) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", {out_zero, out_result}, held_val);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("stale_out", out_valid, 1'b0);
        else check("out_data", {out_zero, out_result}, exp_q.pop_front());
      end
      held     = out_valid && !out_ready;
      held_val = {out_zero, out_result};
    end
  end

  // Starts and ends at posedge+1.
  task automatic offer(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                       input logic [3:0] res, input logic z, output bit acc);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sel   = sel;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk);
    if (acc) exp_q.push_back({z, res});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (n < 200 && (exp_q.size() != 0 || out_valid)) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_drained"}, out_valid, 1'b0);
    check({tag, "_all_delivered"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int acc_cnt;
    int v0;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 4'd0);
    check("rst_out_zero", out_zero, 1'b0);
    check("rst_alu_ops", {alu_a, alu_b, alu_sel}, 11'd0);
`ifdef ALU_ISSUE_CNT_EN
    check("rst_ops_done", ops_done, 8'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Latency: 3+5, accepted at E0, head in cycle 1, visible after E1.
    in_valid = 1'b1; in_a = 4'd3; in_b = 4'd5; in_sel = 3'b000;
    @(negedge clk);
    check("lat_in_ready", in_ready, 1'b1);
    @(posedge clk);
    exp_q.push_back({1'b0, 4'd8});
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_c1_valid", out_valid, 1'b0);
    check("lat_c1_head", {alu_a, alu_b, alu_sel}, {4'd3, 4'd5, 3'b000});
    @(negedge clk);
    check("lat_c2_valid", out_valid, 1'b1);
    check("lat_c2_result", out_result, 4'd8);
    check("lat_c2_zero", out_zero, 1'b0);
    check("lat_c2_alu_empty", {alu_a, alu_b, alu_sel}, 11'd0);
    @(negedge clk);
    check("lat_c3_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Zero-flag and wrap cases.
    offer(4'h5, 4'h5, 3'b001, 4'h0, 1'b1, acc);
    offer(4'hF, 4'h1, 3'b000, 4'h0, 1'b1, acc);
    offer(4'h5, 4'h0, 3'b110, 4'hA, 1'b0, acc);
    offer(4'h6, 4'h6, 3'b100, 4'h0, 1'b1, acc);
    offer(4'h2, 4'h7, 3'b001, 4'hB, 1'b0, acc);
    drain("zero");

    // Full back-pressure: DEPTH queued + 1 held.
    out_ready = 1'b0;
    acc_cnt = 0;
    offer(4'h1, 4'h2, 3'b000, 4'h3, 1'b0, acc); acc_cnt += int'(acc);
    offer(4'h7, 4'h1, 3'b001, 4'h6, 1'b0, acc); acc_cnt += int'(acc);
    offer(4'h4, 4'h4, 3'b000, 4'h8, 1'b0, acc); acc_cnt += int'(acc);
    offer(4'h9, 4'h3, 3'b001, 4'h6, 1'b0, acc); acc_cnt += int'(acc);
    offer(4'h2, 4'hE, 3'b000, 4'h0, 1'b1, acc); acc_cnt += int'(acc);
    offer(4'h1, 4'h1, 3'b000, 4'h2, 1'b0, acc); acc_cnt += int'(acc);
    check("bp_accepts", acc_cnt, 5);
    check("bp_sixth_refused", acc, 1'b0);
    repeat (3) @(negedge clk);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_held_valid", out_valid, 1'b1);
    check("bp_held_result", out_result, 4'h3);
    check("bp_head", {alu_a, alu_b, alu_sel}, {4'h7, 4'h1, 3'b001});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("bp");

    // Back-to-back stream: one result per cycle, in_ready never drops.
    acc_cnt = 0;
    v0 = valid_cycles;
    for (int k = 0; k < 10; k++) begin
      logic [3:0] a4;
      logic [3:0] b4;
      a4 = 4'(k + 2);
      b4 = 4'(k);
      if (k % 2 == 0) offer(a4, b4, 3'b000, 4'(2 * k + 2), (4'(2 * k + 2) == 4'd0), acc);
      else offer(a4, b4, 3'b001, 4'd2, 1'b0, acc);
      acc_cnt += int'(acc);
    end
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    check("b2b_accepts", acc_cnt, 10);
    check("b2b_valid_cycles", valid_cycles - v0, 10);
    @(negedge clk);
    #1;
    check("b2b_end_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    drain("b2b");

    // Reset with 3 queued and 1 held.
    out_ready = 1'b0;
    acc_cnt = 0;
    offer(4'h3, 4'h4, 3'b000, 4'h7, 1'b0, acc); acc_cnt += int'(acc);
    offer(4'h6, 4'h1, 3'b000, 4'h7, 1'b0, acc); acc_cnt += int'(acc);
    offer(4'h9, 4'h2, 3'b001, 4'h7, 1'b0, acc); acc_cnt += int'(acc);
    offer(4'h1, 4'h1, 3'b000, 4'h2, 1'b0, acc); acc_cnt += int'(acc);
    check("mid_accepts", acc_cnt, 4);
    check("mid_pre_valid", out_valid, 1'b1);
    check("mid_pre_result", out_result, 4'h7);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_result", out_result, 4'd0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_alu", {alu_a, alu_b, alu_sel}, 11'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_no_stale_valid", out_valid, 1'b0);
    check("mid_fifo_empty", {alu_a, alu_b, alu_sel}, 11'd0);
    @(posedge clk);
    #1;

`ifdef ALU_ISSUE_CNT_EN
    // Counter wrap: 257 deliveries after reset leave ops_done at 1.
    for (int k = 0; k < 257; k++) begin
      offer(4'(k), 4'd1, 3'b000, 4'(k + 1), (4'(k + 1) == 4'd0), acc);
    end
    drain("cnt");
    check("cnt_wrap", ops_done, 8'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
